// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } mdu_state_e;

    localparam logic [31:0] DIV0_QUOT   = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN     = 32'h8000_0000;
    localparam int          MDU_LATENCY = 34;

    function automatic logic op_is_div(input mdu_op_e op);
        return op[2];
    endfunction

    function automatic logic op_a_signed(input mdu_op_e op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_b_signed(input mdu_op_e op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with fixed 34-cycle latency and a
// one-cycle register-file write-back pulse.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    input  logic            kill,
    output logic            busy,
    output logic            done,
    output logic            wb_we,
    output logic [4:0]      wb_addr,
    output logic [XLEN-1:0] wb_data
);

    mdu_state_e      state_q, state_d;
    mdu_op_e         op_q, op_d;
    logic [4:0]      rd_q, rd_d;
    logic            a_neg_q, a_neg_d;
    logic            b_neg_q, b_neg_d;
    logic            b_zero_q, b_zero_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;

    mdu_op_e           op_in;
    logic              a_neg_in, b_neg_in;
    logic [XLEN-1:0]   a_mag_in, b_mag_in;
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_fix, result;

    always_comb begin
        op_in    = mdu_op_e'(funct3);
        a_neg_in = op_a_signed(op_in) & op_a[XLEN-1];
        b_neg_in = op_b_signed(op_in) & op_b[XLEN-1];
        a_mag_in = a_neg_in ? (~op_a + 1'b1) : op_a;
        b_mag_in = b_neg_in ? (~op_b + 1'b1) : op_b;

        // hi:lo is the running product for multiply, remainder:quotient for divide
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        div_shift = {hi_q, lo_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, b_q};

        prod_fix = (a_neg_q ^ b_neg_q) ? (~{hi_q, lo_q} + 1'b1) : {hi_q, lo_q};
        quot_fix = b_zero_q ? DIV0_QUOT :
                   ((a_neg_q ^ b_neg_q) ? (~lo_q + 1'b1) : lo_q);
        rem_fix  = a_neg_q ? (~hi_q + 1'b1) : hi_q;

        unique case (op_q)
            OP_MUL:                       result = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: result = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              result = quot_fix;
            default:                      result = rem_fix;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        rd_d      = rd_q;
        a_neg_d   = a_neg_q;
        b_neg_d   = b_neg_q;
        b_zero_d  = b_zero_q;
        b_d       = b_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        cnt_d     = cnt_q;
        wb_data_d = wb_data_q;

        unique case (state_q)
            IDLE: begin
                if (start && !kill) begin
                    state_d  = CALC;
                    op_d     = op_in;
                    rd_d     = rd_in;
                    a_neg_d  = a_neg_in;
                    b_neg_d  = b_neg_in;
                    b_zero_d = (op_b == '0);
                    b_d      = b_mag_in;
                    hi_d     = '0;
                    lo_d     = a_mag_in;
                    cnt_d    = '0;
                end
            end
            CALC: begin
                if (kill) begin
                    state_d = IDLE;
                end else begin
                    if (op_is_div(op_q)) begin
                        if (!div_diff[XLEN]) begin
                            hi_d = div_diff[XLEN-1:0];
                            lo_d = {lo_q[XLEN-2:0], 1'b1};
                        end else begin
                            hi_d = div_shift[XLEN-1:0];
                            lo_d = {lo_q[XLEN-2:0], 1'b0};
                        end
                    end else begin
                        hi_d = mul_sum[XLEN:1];
                        lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(XLEN - 1)) begin
                        state_d = FIX;
                    end
                end
            end
            FIX: begin
                if (kill) begin
                    state_d = IDLE;
                end else begin
                    state_d   = DONE;
                    wb_data_d = result;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            op_q      <= OP_MUL;
            rd_q      <= '0;
            a_neg_q   <= 1'b0;
            b_neg_q   <= 1'b0;
            b_zero_q  <= 1'b0;
            b_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            cnt_q     <= '0;
            wb_data_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            rd_q      <= rd_d;
            a_neg_q   <= a_neg_d;
            b_neg_q   <= b_neg_d;
            b_zero_q  <= b_zero_d;
            b_q       <= b_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            cnt_q     <= cnt_d;
            wb_data_q <= wb_data_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign wb_we   = done && (rd_q != 5'd0);
    assign wb_addr = rd_q;
    assign wb_data = wb_data_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomized checks of muldiv_unit against a 64-bit arithmetic reference.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a, op_b;
    logic [4:0]  rd_in;
    logic        kill;
    logic        busy, done, wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    int checks = 0;
    int errors = 0;

    muldiv_unit dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .rd_in  (rd_in),
        .kill   (kill),
        .busy   (busy),
        .done   (done),
        .wb_we  (wb_we),
        .wb_addr(wb_addr),
        .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] b);
        logic signed [63:0] sa, sb;
        logic [63:0]        ua, ub, p;
        logic signed [31:0] s_a, s_b, s_r;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        s_a = a;
        s_b = b;
        s_r = 0;
        p   = 64'd0;
        case (f3)
            3'd0: begin p = ua * ub; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                s_r = s_a / s_b;
                return s_r;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                s_r = s_a % s_b;
                return s_r;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Issues one op in the current cycle (cycle 0) and follows it to completion.
    // restart_cyc > 0 re-pulses start with fresh operands; kill_cyc > 0 aborts.
    task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input int restart_cyc, input int kill_cyc);
        logic [31:0] exp;
        logic [31:0] got_data;
        logic        got_we;
        logic [4:0]  got_addr;
        int          done_cyc;
        int          busy_cnt;
        logic        busy_end;
        exp      = ref_result(f3, a, b);
        done_cyc = -1;
        busy_cnt = 0;
        busy_end = 1'b1;
        got_data = '0;
        got_we   = 1'b0;
        got_addr = '0;
        start  = 1'b1;
        funct3 = f3;
        op_a   = a;
        op_b   = b;
        rd_in  = rd;
        kill   = 1'b0;
        for (int c = 1; c <= 35; c++) begin
            tick();
            start  = (c == restart_cyc);
            kill   = (c == kill_cyc);
            op_a   = $urandom;
            op_b   = $urandom;
            rd_in  = 5'($urandom);
            funct3 = 3'($urandom);
            if (done && done_cyc < 0) begin
                done_cyc = c;
                got_data = wb_data;
                got_we   = wb_we;
                got_addr = wb_addr;
            end
            if (c <= 34 && busy) busy_cnt++;
            if (c == 35) busy_end = busy;
            if (kill_cyc > 0 && c == kill_cyc + 1) begin
                busy_end = busy;
                break;
            end
        end
        start = 1'b0;
        kill  = 1'b0;
        if (kill_cyc > 0) begin
            check({name, "_killed_no_done"}, 32'(done_cyc < 0), 32'd1);
            check({name, "_killed_busy_low"}, {31'b0, busy_end}, 32'd0);
        end else begin
            check({name, "_latency"}, 32'(done_cyc), 32'd34);
            check({name, "_data"}, got_data, exp);
            check({name, "_we"}, {31'b0, got_we}, {31'b0, rd != 5'd0});
            check({name, "_addr"}, {27'b0, got_addr}, {27'b0, rd});
            check({name, "_busy_span"}, 32'(busy_cnt), 32'd34);
            check({name, "_busy_drop"}, {31'b0, busy_end}, 32'd0);
        end
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 9))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        kill   = 1'b0;
        funct3 = 3'd0;
        op_a   = '0;
        op_b   = '0;
        rd_in  = '0;
        #12;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_we", {31'b0, wb_we}, 32'd0);
        check("rst_addr", {27'b0, wb_addr}, 32'd0);
        check("rst_data", wb_data, 32'd0);
        reset = 1'b0;
        tick();

        run_op("mul_7x6", 3'd0, 32'd7, 32'd6, 5'd5, 0, 0);
        run_op("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 0, 0);
        run_op("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000, 5'd7, 0, 0);
        run_op("mulhsu_m1x2", 3'd2, 32'hFFFF_FFFF, 32'd2, 5'd8, 0, 0);
        run_op("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd9, 0, 0);
        run_op("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd10, 0, 0);
        run_op("divu_100_7", 3'd5, 32'd100, 32'd7, 5'd11, 0, 0);
        run_op("remu_100_7", 3'd7, 32'd100, 32'd7, 5'd12, 0, 0);
        run_op("div_by0", 3'd4, 32'd5, 32'd0, 5'd13, 0, 0);
        run_op("rem_by0", 3'd6, 32'd5, 32'd0, 5'd14, 0, 0);
        run_op("divu_by0", 3'd5, 32'd5, 32'd0, 5'd15, 0, 0);
        run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 0, 0);
        run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 0, 0);

        run_op("mul_rd0", 3'd0, 32'd3, 32'd4, 5'd0, 0, 0);
        run_op("restart_ignored", 3'd0, 32'd11, 32'd13, 5'd3, 10, 0);
        run_op("kill_c20", 3'd5, 32'd1000, 32'd3, 5'd4, 0, 20);
        run_op("after_kill", 3'd0, 32'd9, 32'd9, 5'd18, 0, 0);

        for (int i = 0; i < 24; i++) begin
            run_op($sformatf("rand%0d", i), 3'($urandom), pick_operand(), pick_operand(),
                   5'($urandom), 0, 0);
        end

        // Leave a nonzero result in wb_data, then reset asynchronously mid-CALC.
        run_op("pre_reset", 3'd0, 32'd5, 32'd5, 5'd19, 0, 0);
        start  = 1'b1;
        funct3 = 3'd4;
        op_a   = 32'd77;
        op_b   = 32'd5;
        rd_in  = 5'd20;
        tick();
        start = 1'b0;
        repeat (9) tick();
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_busy", {31'b0, busy}, 32'd0);
        check("async_rst_done", {31'b0, done}, 32'd0);
        check("async_rst_we", {31'b0, wb_we}, 32'd0);
        check("async_rst_data", wb_data, 32'd0);
        check("async_rst_addr", {27'b0, wb_addr}, 32'd0);
        tick();
        #3;
        reset = 1'b0;
        tick();
        run_op("divu_9_3", 3'd5, 32'd9, 32'd3, 5'd21, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit.
- Sits between register-file read and register-file write:
  - consumes operand A (rd1) and operand B (rd2) plus funct3 and the destination register index;
  - produces a one-cycle write-back triple (wb_we, wb_addr, wb_data) that drives reg_file we3/a3/wd3 through the writeback mux.
- Fixed latency for every operation, so the control unit can stall deterministically.

Parameters:
- XLEN, 32, operand/result width. Only 32 is supported.
- CNT_W, $clog2(XLEN), width of the iteration counter.

Ports:
- clk       in   1      rising-edge clock
- reset     in   1      asynchronous, active-high reset
- start     in   1      request; sampled only when busy=0
- funct3    in   3      op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op_a      in   XLEN   rs1 value (from rd1)
- op_b      in   XLEN   rs2 value (from rd2)
- rd_in     in   5      destination register index
- kill      in   1      pipeline flush; aborts the in-flight op
- busy      out  1      high from the cycle after start is accepted until done
- done      out  1      one-cycle pulse, result valid
- wb_we     out  1      done && (rd_q != 0)
- wb_addr   out  5      latched rd_in
- wb_data   out  XLEN   result

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - state=IDLE;
  - busy, done and wb_we = 0;
  - wb_addr = 0 and wb_data = 0;
  - all internal registers cleared.
- States and transitions:
  - IDLE -> CALC on start && !kill.
  - CALC -> FIX after XLEN iterations.
  - FIX -> DONE.
  - DONE -> IDLE.
- Accept edge:
  - latch funct3, rd_in and the operand magnitudes;
  - latch the sign flags for the signed ops (MULH both signed; MULHSU only op_a signed; DIV/REM both signed);
  - counter = 0.
- Latency:
  - start high in cycle 0;
  - busy high in cycles 1..34;
  - done = wb_we-eligible pulse in cycle 34;
  - busy drops in cycle 35.
  - Identical for all eight ops and all special cases.
- CALC, one step per clock, XLEN steps:
  - Multiply: shift-add on a 2*XLEN product of unsigned magnitudes.
  - Divide: restoring shift-subtract on unsigned magnitudes, producing quotient and remainder.
- FIX: apply sign correction.
  - Product is negated if the operand signs differ.
  - Quotient is negated if the signs differ.
  - Remainder takes the sign of the dividend.
  - Select the result:
    - MUL = low word;
    - MULH/MULHSU/MULHU = high word;
    - DIV/DIVU = quotient;
    - REM/REMU = remainder.
- Special cases (RISC-V spec; resolved in FIX, latency unchanged):
  - Divide by zero: quotient = 0xFFFFFFFF (DIV and DIVU); remainder = op_a.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): DIV = 0x80000000, REM = 0.
- DONE cycle:
  - done = 1; wb_data = result; wb_addr = rd_q.
  - wb_we = 1 only when rd_q != 0.
- Outside DONE:
  - done = 0 and wb_we = 0.
  - wb_data holds its last value (no X).
- Handshakes and aborts:
  - start while busy=1 is ignored; operands are not re-sampled.
  - start in the DONE cycle is ignored (busy is still 1).
  - kill in CALC or FIX -> IDLE on the next edge; no done and no wb_we are ever produced for that op.
  - kill in the DONE cycle does not suppress the already-asserted pulse.
  - kill && start together in IDLE -> the op is not accepted.
  - Operands are captured at accept, so op_a/op_b may change freely while busy.

Decomposition:
- Package muldiv_pkg holds:
  - mdu_op_e enum over the funct3 encodings above;
  - mdu_state_e enum {IDLE, CALC, FIX, DONE};
  - constants DIV0_QUOT = 32'hFFFFFFFF, INT_MIN = 32'h80000000, MDU_LATENCY = 34.
- No sub-module is required.
- One datapath register pair (acc/hi, q/lo) is shared between multiply and divide in a single module.

Test Plan:
- MUL 7 x 6, rd=5 -> done in cycle 34, wb_we=1, wb_addr=5, wb_data=42. Then MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHSU 0xFFFFFFFF(-1) x 2 -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD (-3). REM -7/2 -> 0xFFFFFFFF (-1). DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIV 5/0 -> 0xFFFFFFFF. REM 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM of the same -> 0. Each at the same 34-cycle latency.
- Protocol sequence:
  - MUL with rd=0 -> done=1, wb_we=0.
  - start re-pulsed in cycle 10 with new operands -> ignored; the original result is unchanged.
  - kill in cycle 20 -> no done; busy=0 in cycle 21; a new start is accepted immediately.
- reset asserted asynchronously mid-CALC (between edges) -> busy, done, wb_we and wb_data drop to 0 immediately. After release, a fresh DIVU 9/3 returns 3.
